uart_calc_ctrl: RTL

Parametrised UART command/response controller between the uart core and a pipelined arithmetic unit (FP_add_sub, FP_mult or a later multi-function unit).
- Receives one opcode byte, then NUM_OPS operands of DATA_W bits, MSB byte first.
- Launches the arithmetic unit, waits CALC_LAT cycles, captures the result and transmits it back MSB byte first.
- Adds what the current fixed 2x32-bit flow lacks: opcode selection, configurable width/operand count/latency, inter-byte timeout resync and overrun flagging.

---
 rtl/uart_calc_pkg.sv | 29 ++
 rtl/uart_calc_edge.sv | 26 ++
 rtl/uart_calc_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_calc_pkg.sv
// Shared types and helpers for the UART calculator command/response controller.
// Optional build macro (used by uart_calc_ctrl): UART_CALC_CHECKSUM_EN.
package uart_calc_pkg;

  // RX_CHK and TX_CHK exist in every build so state encodings do not depend
  // on the checksum option.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RX_OPS = 3'd1,
    RX_CHK = 3'd2,
    CALC   = 3'd3,
    TX     = 3'd4,
    TX_CHK = 3'd5
  } state_t;

  // Reply sent instead of a result when a command's checksum does not match.
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  // Widest supported operand/result, in bits.
  localparam int MAX_W = 64;

  // MSB-first byte extraction. The word is left-justified in 64 bits, so
  // idx 0 is always the most significant byte whatever the real width is.
  function automatic logic [7:0] byte_sel(input logic [MAX_W-1:0] word,
                                          input logic [2:0] idx);
    return word[8*(7-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/uart_calc_edge.sv
// Registered rising-edge detector for the uart receive-done level.
// Produces one strobe cycle per byte, one cycle after rx_done rises.
module uart_calc_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_lvl,
  output logic o_stb
);

  logic r_lvl_d;
  logic r_stb;

  // Delay the level by one cycle and register the rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lvl_d <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      r_lvl_d <= i_lvl;
      r_stb   <= i_lvl & ~r_lvl_d;
    end
  end

  assign o_stb = r_stb;

endmodule

// File: rtl/uart_calc_ctrl.sv
// UART command/response controller for a pipelined arithmetic unit.
// Receives an opcode and NUM_OPS operands (MSB byte first), launches the
// unit, waits CALC_LAT cycles, and transmits the result MSB byte first.
// Optional build macro: UART_CALC_CHECKSUM_EN adds an XOR checksum byte to
// every received command and every transmitted result.
//
// state  | meaning
// IDLE   | waiting for an opcode byte
// RX_OPS | collecting operand bytes, inter-byte timeout armed
// RX_CHK | waiting for the command checksum byte (checksum builds only)
// CALC   | arithmetic unit running, counting latency
// TX     | sending result bytes, one per tx_done
// TX_CHK | sending the result checksum or the NAK byte
module uart_calc_ctrl
  import uart_calc_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_OPS     = 2,
  parameter int CALC_LAT    = 14,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_done,
  input  logic [7:0]                rx_data,
  input  logic                      tx_done,
  output logic                      send_data,
  output logic [7:0]                tx_data,
  output logic [7:0]                op_code,
  output logic [NUM_OPS*DATA_W-1:0] operands,
  output logic                      calc_start,
  input  logic [DATA_W-1:0]         result_in,
  output logic                      busy,
  output logic                      err_timeout,
  output logic                      err_overrun
);

  localparam int  BYTES     = DATA_W / 8;
  localparam int  TOT_BYTES = NUM_OPS * BYTES;
  localparam int  LSB_W     = $clog2(NUM_OPS * DATA_W);
  localparam bit  TO_EN     = (TIMEOUT_CYC > 0);
  localparam int  GAP_W     = TO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_t                    r_state;
  logic [5:0]                r_byte_cnt;
  logic [7:0]                r_lat_cnt;
  logic [GAP_W-1:0]          r_gap_cnt;
  logic [2:0]                r_tx_idx;
  logic                      r_res_rdy;
  logic [DATA_W-1:0]         r_res_q;
  logic [7:0]                r_op_code;
  logic [7:0]                r_tx_data;
  logic [NUM_OPS*DATA_W-1:0] r_operands;
  logic                      r_send;
  logic                      r_calc_start;
  logic                      r_err_to;
  logic                      r_err_ov;

  logic                      w_rx_stb;
  logic [MAX_W-1:0]          w_res_left;
  logic [LSB_W-1:0]          w_wr_lsb;
  logic                      w_last_rx;
  logic                      w_last_tx;
  logic                      w_timeout;

`ifdef UART_CALC_CHECKSUM_EN
  logic [7:0]                r_chk;
  logic [7:0]                w_res_chk;
`endif

  uart_calc_edge u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .i_lvl (rx_done),
    .o_stb (w_rx_stb)
  );

  // Byte placement, end-of-frame and timeout decodes.
  always_comb begin
    w_res_left = MAX_W'(r_res_q) << (MAX_W - DATA_W);
    w_wr_lsb   = LSB_W'((int'(r_byte_cnt) / BYTES) * DATA_W
                      + (BYTES - 1 - (int'(r_byte_cnt) % BYTES)) * 8);
    w_last_rx  = (r_byte_cnt == 6'(TOT_BYTES - 1));
    w_last_tx  = (r_tx_idx == 3'(BYTES - 1));
    w_timeout  = TO_EN && (r_gap_cnt == GAP_W'(TIMEOUT_CYC));
  end

`ifdef UART_CALC_CHECKSUM_EN
  // XOR of all result bytes, sent after the last result byte.
  always_comb begin
    w_res_chk = 8'h00;
    for (int i = 0; i < BYTES; i++) begin
      w_res_chk = w_res_chk ^ r_res_q[8*i +: 8];
    end
  end
`endif

  // Command/response sequencer; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_byte_cnt   <= '0;
      r_lat_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_tx_idx     <= '0;
      r_res_rdy    <= 1'b0;
      r_res_q      <= '0;
      r_op_code    <= '0;
      r_tx_data    <= '0;
      r_operands   <= '0;
      r_send       <= 1'b0;
      r_calc_start <= 1'b0;
      r_err_to     <= 1'b0;
      r_err_ov     <= 1'b0;
`ifdef UART_CALC_CHECKSUM_EN
      r_chk        <= '0;
`endif
    end else begin
      r_send       <= 1'b0;
      r_calc_start <= 1'b0;
      r_err_to     <= 1'b0;
      r_err_ov     <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_rx_stb) begin
            r_op_code  <= rx_data;
            r_byte_cnt <= '0;
            r_gap_cnt  <= '0;
`ifdef UART_CALC_CHECKSUM_EN
            r_chk      <= rx_data;
`endif
            r_state    <= RX_OPS;
          end
        end

        RX_OPS: begin
          // Expiry beats a byte arriving in the same cycle.
          if (w_timeout) begin
            r_err_to  <= 1'b1;
            r_gap_cnt <= '0;
            r_state   <= IDLE;
          end else if (w_rx_stb) begin
            r_operands[w_wr_lsb +: 8] <= rx_data;
            r_gap_cnt <= '0;
`ifdef UART_CALC_CHECKSUM_EN
            r_chk     <= r_chk ^ rx_data;
`endif
            if (w_last_rx) begin
              r_byte_cnt <= '0;
`ifdef UART_CALC_CHECKSUM_EN
              r_state    <= RX_CHK;
`else
              r_calc_start <= 1'b1;
              r_lat_cnt    <= '0;
              r_state      <= CALC;
`endif
            end else begin
              r_byte_cnt <= r_byte_cnt + 6'd1;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

`ifdef UART_CALC_CHECKSUM_EN
        RX_CHK: begin
          if (w_timeout) begin
            r_err_to  <= 1'b1;
            r_gap_cnt <= '0;
            r_state   <= IDLE;
          end else if (w_rx_stb) begin
            r_gap_cnt <= '0;
            if (rx_data == r_chk) begin
              r_calc_start <= 1'b1;
              r_lat_cnt    <= '0;
              r_state      <= CALC;
            end else begin
              // Bad frame: no launch, answer with a lone NAK byte.
              r_tx_data <= NAK_BYTE;
              r_send    <= 1'b1;
              r_state   <= TX_CHK;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
`endif

        CALC: begin
          if (w_rx_stb) r_err_ov <= 1'b1;
          // lat_cnt reads k in the k-th cycle after calc_start, so the
          // capture samples result_in exactly CALC_LAT cycles after launch.
          if (r_res_rdy) begin
            r_res_rdy <= 1'b0;
            r_lat_cnt <= '0;
            r_tx_idx  <= '0;
            r_tx_data <= byte_sel(w_res_left, 3'd0);
            r_send    <= 1'b1;
            r_state   <= TX;
          end else if (r_lat_cnt == 8'(CALC_LAT)) begin
            r_res_q   <= result_in;
            r_res_rdy <= 1'b1;
          end else begin
            r_lat_cnt <= r_lat_cnt + 8'd1;
          end
        end

        TX: begin
          if (w_rx_stb) r_err_ov <= 1'b1;
          if (tx_done) begin
            if (w_last_tx) begin
              r_tx_idx  <= '0;
`ifdef UART_CALC_CHECKSUM_EN
              r_tx_data <= w_res_chk;
              r_send    <= 1'b1;
              r_state   <= TX_CHK;
`else
              r_state   <= IDLE;
`endif
            end else begin
              r_tx_idx  <= r_tx_idx + 3'd1;
              r_tx_data <= byte_sel(w_res_left, r_tx_idx + 3'd1);
              r_send    <= 1'b1;
            end
          end
        end

        TX_CHK: begin
          if (w_rx_stb) r_err_ov <= 1'b1;
          if (tx_done) r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign send_data   = r_send;
  assign tx_data     = r_tx_data;
  assign op_code     = r_op_code;
  assign operands    = r_operands;
  assign calc_start  = r_calc_start;
  assign busy        = (r_state != IDLE);
  assign err_timeout = r_err_to;
  assign err_overrun = r_err_ov;

endmodule
